// File: rtl/uart_loader_ctrl.sv
// UART program loader and CPU run control.
// Accepts single-byte commands and length-prefixed instruction-memory images.
module uart_loader_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_WORD     = 32,
    parameter int NB_ADDR     = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_WORD-1:0] o_imem_wdata,
    output logic               o_cpu_rst,
    output logic               o_cpu_run,
    output logic               o_cpu_step,
    output logic               o_busy,
    output logic               o_err
);

    localparam int BYTES   = NB_WORD / NB_DATA;
    localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int NB_TMO  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [NB_BCNT-1:0] BCNT_LAST = NB_BCNT'(BYTES - 1);
    localparam logic [NB_TMO-1:0]  TMO_LAST  = NB_TMO'(TIMEOUT_CYC - 1);
    localparam logic [32:0]        WORDS_MAX = 33'(1) << NB_ADDR;

    localparam logic [NB_DATA-1:0] CMD_L = NB_DATA'(8'h4C);
    localparam logic [NB_DATA-1:0] CMD_R = NB_DATA'(8'h52);
    localparam logic [NB_DATA-1:0] CMD_H = NB_DATA'(8'h48);
    localparam logic [NB_DATA-1:0] CMD_S = NB_DATA'(8'h53);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic [NB_WORD-1:0]   wdata_q, wdata_d;
    logic [NB_BCNT-1:0]   bcnt_q, bcnt_d;
    logic [NB_TMO-1:0]    tmo_q, tmo_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 run_q, run_d;
    logic                 step_q, step_d;
    logic                 err_q, err_d;

    logic [7:0]  rx_byte;
    logic [15:0] n_words;
    logic        is_l, is_r, is_h, is_s;
    logic        in_frame;

    assign rx_byte  = 8'(i_rx_data);
    assign n_words  = {rx_byte, len_q[7:0]};
    assign is_l     = (i_rx_data == CMD_L);
    assign is_r     = (i_rx_data == CMD_R);
    assign is_h     = (i_rx_data == CMD_H);
    assign is_s     = (i_rx_data == CMD_S);
    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI)
                   || (state_q == DATA);

    // State register and all datapath/control registers.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            cpu_rst_q <= 1'b1;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            cpu_rst_q <= cpu_rst_d;
            run_q     <= run_d;
            step_q    <= step_d;
            err_q     <= err_d;
        end
    end

    // Next-state: command decode, frame parsing, word assembly, timeout.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bcnt_d    = bcnt_q;
        tmo_d     = '0;
        cpu_rst_d = cpu_rst_q;
        run_d     = run_q;
        step_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    unique case (1'b1)
                        is_l: begin
                            state_d   = LEN_LO;
                            cpu_rst_d = 1'b1;
                            run_d     = 1'b0;
                            err_d     = 1'b0;
                        end
                        is_r: begin
                            run_d     = 1'b1;
                            cpu_rst_d = 1'b0;
                            err_d     = 1'b0;
                        end
                        is_h: begin
                            run_d     = 1'b0;
                            cpu_rst_d = 1'b0;
                            err_d     = 1'b0;
                        end
                        is_s: begin
                            step_d = !run_q && !cpu_rst_q;
                            err_d  = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            LEN_LO: begin
                if (i_rx_done) begin
                    len_d[7:0] = rx_byte;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (i_rx_done) begin
                    if (n_words == 16'd0) begin
                        state_d   = IDLE;
                        cpu_rst_d = 1'b0;
                    end else if (33'(n_words) > WORDS_MAX) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                        len_d   = n_words;
                        addr_d  = '0;
                        bcnt_d  = '0;
                    end
                end
            end
            DATA: begin
                if (i_rx_done) begin
                    wdata_d[int'(bcnt_q)*NB_DATA +: NB_DATA] = i_rx_data;
                    if (bcnt_q == BCNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (len_q == 16'd1) begin
                    len_d     = '0;
                    state_d   = IDLE;
                    cpu_rst_d = 1'b0;
                end else begin
                    len_d   = len_q - 16'd1;
                    addr_d  = addr_q + 1'b1;
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte silence inside a frame aborts it.
        if (in_frame && !i_rx_done) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
                bcnt_d  = '0;
                wdata_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign o_imem_we    = (state_q == WRITE);
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_cpu_run    = run_q;
    assign o_cpu_step   = step_q;
    assign o_busy       = (state_q != IDLE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Bench for uart_loader_ctrl: scoreboarded memory writes and
// step pulses plus directed status checks.
module tb_uart_loader_ctrl;

    localparam int NB_DATA = 8;
    localparam int NB_WORD = 32;
    localparam int NB_ADDR = 10;
    localparam int TMO     = 40;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic [NB_DATA-1:0] i_rx_data = '0;
    logic               i_rx_done = 1'b0;
    logic               o_imem_we;
    logic [NB_ADDR-1:0] o_imem_addr;
    logic [NB_WORD-1:0] o_imem_wdata;
    logic               o_cpu_rst;
    logic               o_cpu_run;
    logic               o_cpu_step;
    logic               o_busy;
    logic               o_err;

    typedef struct {
        logic [NB_ADDR-1:0] a;
        logic [NB_WORD-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t cur;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  step_cnt = 0;

    uart_loader_ctrl #(
        .NB_DATA(NB_DATA),
        .NB_WORD(NB_WORD),
        .NB_ADDR(NB_ADDR),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .i_rst(i_rst),
        .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done),
        .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_wdata(o_imem_wdata),
        .o_cpu_rst(o_cpu_rst),
        .o_cpu_run(o_cpu_run),
        .o_cpu_step(o_cpu_step),
        .o_busy(o_busy),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push(input logic [NB_ADDR-1:0] a,
                        input logic [NB_WORD-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Monitor: pop one expected write per strobe, count step pulses.
    always @(negedge clk) begin
        if (o_cpu_step) step_cnt++;
        if (o_imem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: addr %h data %h, none expected",
                         o_imem_addr, o_imem_wdata);
            end else begin
                cur = exp_q.pop_front();
                chk("wr_addr", 32'(o_imem_addr), 32'(cur.a));
                chk("wr_data", o_imem_wdata, cur.d);
            end
        end
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(o_imem_we), 0);
        chk("rst_addr", 32'(o_imem_addr), 0);
        chk("rst_wdata", o_imem_wdata, 0);
        chk("rst_cpu_rst", 32'(o_cpu_rst), 1);
        chk("rst_run", 32'(o_cpu_run), 0);
        chk("rst_step", 32'(o_cpu_step), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_err", 32'(o_err), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word load.
        push(10'd0, 32'h12345678);
        push(10'd1, 32'hDEADBEEF);
        send(8'h4C);
        chk("load_busy", 32'(o_busy), 1);
        chk("load_cpu_rst", 32'(o_cpu_rst), 1);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("load_midword_we", 32'(o_imem_we), 0);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("load_done_cpu_rst", 32'(o_cpu_rst), 0);
        chk("load_done_busy", 32'(o_busy), 0);
        chk("load_q_empty", 32'(exp_q.size()), 0);

        // Three-word load, address increments past 1.
        push(10'd0, 32'h00000001);
        push(10'd1, 32'hFFFFFFFF);
        push(10'd2, 32'h76543210);
        send(8'h4C); send(8'h03); send(8'h00);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h10); send(8'h32); send(8'h54); send(8'h76);
        chk("load3_cpu_rst", 32'(o_cpu_rst), 0);
        chk("load3_q_empty", 32'(exp_q.size()), 0);

        // Run/halt/step.
        send(8'h52);
        chk("run_on", 32'(o_cpu_run), 1);
        send(8'h53);
        chk("step_while_run", step_cnt, 0);
        send(8'h48);
        chk("run_off", 32'(o_cpu_run), 0);
        send(8'h53);
        chk("step_once", step_cnt, 1);
        chk("step_err", 32'(o_err), 0);

        // Timeout mid-frame.
        send(8'h4C); send(8'h01); send(8'h00); send(8'hAA);
        chk("tmo_pre_err", 32'(o_err), 0);
        repeat (TMO + 5) @(negedge clk);
        chk("tmo_err", 32'(o_err), 1);
        chk("tmo_busy", 32'(o_busy), 0);
        chk("tmo_cpu_rst", 32'(o_cpu_rst), 1);
        send(8'h52);
        chk("tmo_clr_err", 32'(o_err), 0);
        chk("tmo_run", 32'(o_cpu_run), 1);
        chk("tmo_r_cpu_rst", 32'(o_cpu_rst), 0);

        // Length limits.
        send(8'h4C); send(8'h01); send(8'h04);
        chk("len_big_err", 32'(o_err), 1);
        chk("len_big_busy", 32'(o_busy), 0);
        chk("len_big_cpu_rst", 32'(o_cpu_rst), 1);
        send(8'h4C); send(8'h00); send(8'h00);
        chk("len0_cpu_rst", 32'(o_cpu_rst), 0);
        chk("len0_busy", 32'(o_busy), 0);
        chk("len0_err", 32'(o_err), 0);

        // Unknown command leaves everything else alone.
        send(8'h52);
        send(8'h7E);
        chk("unk_err", 32'(o_err), 1);
        chk("unk_run", 32'(o_cpu_run), 1);
        chk("unk_cpu_rst", 32'(o_cpu_rst), 0);
        chk("unk_busy", 32'(o_busy), 0);

        // Reset mid-frame.
        send(8'h4C); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        chk("mid_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_wdata", o_imem_wdata, 0);
        chk("mid_rst_addr", 32'(o_imem_addr), 0);
        chk("mid_rst_cpu_rst", 32'(o_cpu_rst), 1);
        chk("mid_rst_run", 32'(o_cpu_run), 0);
        chk("mid_rst_err", 32'(o_err), 0);
        i_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("post_rst_cpu_rst", 32'(o_cpu_rst), 1);
        send(8'h48);
        chk("post_rst_h_cpu_rst", 32'(o_cpu_rst), 0);

        repeat (5) @(negedge clk);
        chk("final_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_loader_ctrl.md
UART_LOADER_CTRL -- requirements
Module: uart_loader_ctrl

Interface
REQ-001 SHALL provide parameter NB_DATA, default 8: width of received UART byte.
REQ-002 SHALL provide parameter NB_WORD, default 32: instruction-memory word width; must be a multiple of NB_DATA.
REQ-003 SHALL provide parameter NB_ADDR, default 10: instruction-memory word-address width.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 1000000: maximum idle clk cycles allowed between bytes inside a frame.
REQ-005 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-006 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_rx_data  in  NB_DATA  received byte, valid only while i_rx_done=1.
REQ-008 SHALL have port i_rx_done  in  1  one-cycle pulse per received byte.
REQ-009 SHALL have port o_imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port o_imem_addr  out  NB_ADDR  word address for the write.
REQ-011 SHALL have port o_imem_wdata  out  NB_WORD  assembled word.
REQ-012 SHALL have port o_cpu_rst  out  1  CPU held in reset while high.
REQ-013 SHALL have port o_cpu_run  out  1  CPU free-run enable, level.
REQ-014 SHALL have port o_cpu_step  out  1  single-cycle CPU step pulse.
REQ-015 SHALL have port o_busy  out  1  high in any state other than IDLE.
REQ-016 SHALL have port o_err  out  1  sticky error flag.

Function
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE; only i_rx_done=1 cycles advance IDLE/LEN_LO/LEN_HI/DATA.
REQ-018 SHALL decode in IDLE: 0x4C 'L' -> LEN_LO and o_cpu_rst=1, o_cpu_run=0; 0x52 'R' -> o_cpu_run=1; 0x48 'H' -> o_cpu_run=0; 0x53 'S' -> o_cpu_step=1 on the next cycle, only if o_cpu_run=0 and o_cpu_rst=0.
REQ-019 SHALL treat any other byte in IDLE as unknown: set o_err, stay in IDLE, leave all other outputs unchanged.
REQ-020 SHALL clear o_err on acceptance of any valid command byte, except when the same cycle sets it.
REQ-021 SHALL take word count N as a 16-bit little-endian value: LEN_LO byte = N[7:0], LEN_HI byte = N[15:8].
REQ-022 SHALL, after LEN_HI: N=0 -> IDLE with o_cpu_rst=0; N > 2^NB_ADDR -> set o_err, IDLE, o_cpu_rst stays 1; otherwise -> DATA with the word address cleared to 0.
REQ-023 SHALL assemble NB_WORD/NB_DATA bytes per word, little-endian: first byte -> bits [NB_DATA-1:0].
REQ-024 SHALL go to WRITE after the last byte of a word; WRITE lasts exactly one cycle with o_imem_we=1 and o_imem_addr/o_imem_wdata stable.
REQ-025 SHALL, in the cycle after WRITE, increment the address and go to DATA if words remain, or go to IDLE and drop o_cpu_rst if N words are written.
REQ-026 SHALL hold o_imem_we=0 in every state except WRITE; the address SHALL NOT wrap within a frame (guaranteed by REQ-022).
REQ-027 SHALL count clk cycles since the last i_rx_done while in LEN_LO, LEN_HI or DATA; on reaching TIMEOUT_CYC it SHALL set o_err, discard the partial word, go to IDLE and keep o_cpu_rst=1.
REQ-028 SHALL ignore an i_rx_done pulse that coincides with WRITE; the byte is lost (the sender is paced by UART bit time, so it never arrives).
REQ-029 SHALL leave o_cpu_step high for exactly one cycle per accepted 'S'.

Reset
REQ-030 SHALL, while i_rst=1, force state IDLE, all counters 0, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_cpu_rst=1, o_cpu_run=0, o_cpu_step=0, o_busy=0, o_err=0.
REQ-031 SHALL, on reset assertion mid-frame, abandon the frame with no further o_imem_we pulses; after release, o_cpu_rst stays 1 until a complete load finishes or 'R'/'H' is received in IDLE, and 'R'/'H' SHALL clear o_cpu_rst.

Verification
REQ-032 SHALL pass: bytes 4C 02 00 78 56 34 12 EF BE AD DE -> two o_imem_we pulses, addr0=0x12345678, addr1=0xDEADBEEF, then o_cpu_rst=0, o_busy=0.
REQ-033 SHALL pass: 52, then 53 -> o_cpu_run=1 and no step pulse; then 48, 53 -> o_cpu_run=0 and exactly one o_cpu_step pulse.
REQ-034 SHALL pass: 4C 01 00 AA, then silence for TIMEOUT_CYC cycles -> o_err=1, IDLE, no o_imem_we, o_cpu_rst=1; then 52 -> o_err=0.
REQ-035 SHALL pass: 4C 01 04 (N=1025, NB_ADDR=10) -> o_err=1, no writes; and 4C 00 00 -> no writes, o_cpu_rst=0 immediately.
REQ-036 SHALL pass: 7E in IDLE -> o_err=1, all other outputs unchanged; i_rst pulse after 3 data bytes -> reset values per REQ-030 and no write.
